// File: rtl/edge_det_pkg.sv
// edge_det_pkg: shared mode encoding and edge-match helper for the edge event detector
package edge_det_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_RISE = 2'b00;
   localparam mode_t MODE_FALL = 2'b01;
   localparam mode_t MODE_BOTH = 2'b10;
   localparam mode_t MODE_OFF  = 2'b11;

   // True when a level toggle towards new_level should be reported under mode.
   function automatic logic edge_match(input mode_t mode, input logic new_level);
      return (mode == MODE_BOTH) ||
             (mode == MODE_RISE && new_level) ||
             (mode == MODE_FALL && !new_level);
   endfunction

endpackage

// File: rtl/edge_det_channel.sv
// edge_det_channel: synchroniser, debounce, edge detect and sticky flag for one input
module edge_det_channel
   import edge_det_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  i_signal,
   input  mode_t i_mode,
   input  logic  i_clear,
   output logic  o_pulse,
   output logic  o_level,
   output logic  o_event
);

   localparam int               LIMIT   = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt;
   logic                   sync;
   logic                   differ;
   logic                   flip;
   logic                   hit;

   assign sync = sync_q[SYNC_STAGES-1];

   // A toggle is due once sync has differed from the clean level for LIMIT cycles.
   always_comb begin
      differ = sync != o_level;
      flip   = differ && (cnt == CNT_MAX);
      hit    = flip && edge_match(i_mode, sync);
   end

   // Synchroniser chain, stability counter, clean level, pulse and set-wins sticky flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q  <= '0;
         cnt     <= '0;
         o_level <= 1'b0;
         o_pulse <= 1'b0;
         o_event <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], i_signal};
         cnt     <= (!differ || flip) ? '0 : cnt + CNT_W'(1);
         o_level <= flip ? sync : o_level;
         o_pulse <= hit;
         o_event <= hit | (o_event & ~i_clear);
      end
   end

endmodule

// File: rtl/edge_event_detector.sv
// edge_event_detector: multi-channel debounced edge detector with sticky event flags
module edge_event_detector
   import edge_det_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   i_signal,
   input  logic [2*WIDTH-1:0] i_mode,
   input  logic [WIDTH-1:0]   i_clear,
   output logic [WIDTH-1:0]   o_pulse,
   output logic [WIDTH-1:0]   o_level,
   output logic [WIDTH-1:0]   o_event,
   output logic               o_any
);

   localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

   for (genvar n = 0; n < WIDTH; n++) begin : g_ch
      edge_det_channel #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .i_signal(i_signal[n]),
         .i_mode  (i_mode[2*n +: 2]),
         .i_clear (i_clear[n]),
         .o_pulse (o_pulse[n]),
         .o_level (o_level[n]),
         .o_event (o_event[n])
      );
   end

   assign o_any = |o_event;

endmodule

// File: tb/tb_edge_event_detector.sv
// tb_edge_event_detector: scoreboard bench for the edge event detector
module tb_edge_event_detector;
   import edge_det_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  i_signal;
   logic [7:0]  i_mode;
   logic [3:0]  i_clear;
   logic [3:0]  o_pulse;
   logic [3:0]  o_level;
   logic [3:0]  o_event;
   logic        o_any;
   logic [12:0] obs;

   typedef struct {
      int          at;
      string       tag;
      logic [12:0] val;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   pcnt[4] = '{0, 0, 0, 0};
   int   base[4];
   int   want[4] = '{1, 1, 2, 0};
   int   c0;

   always #5 clk = ~clk;

   edge_event_detector dut (
      .clk     (clk),
      .rst     (rst),
      .i_signal(i_signal),
      .i_mode  (i_mode),
      .i_clear (i_clear),
      .o_pulse (o_pulse),
      .o_level (o_level),
      .o_event (o_event),
      .o_any   (o_any)
   );

   assign obs = {o_any, o_event, o_level, o_pulse};

   function automatic logic [12:0] pack(input logic any, input logic [3:0] ev,
                                        input logic [3:0] lv, input logic [3:0] pu);
      return {any, ev, lv, pu};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic expect_at(input int dt, input string tag, input logic [12:0] v);
      sb.push_back('{cyc + dt, tag, v});
   endtask

   task automatic go(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      check("drain", sb.size(), 0);
      sb.delete();
   endtask

   task automatic clear_all(input logic [3:0] lv);
      expect_at(1, "clear", pack(1'b0, 4'b0000, lv, 4'b0000));
      i_clear = 4'hF;
      @(negedge clk);
      i_clear = 4'h0;
      drain();
   endtask

   initial begin : mon
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         for (int k = 0; k < 4; k++) pcnt[k] += int'(o_pulse[k]);
         while (sb.size() != 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            if (e.at == cyc) check(e.tag, 32'(obs), 32'(e.val));
            else check({e.tag, "_missed"}, cyc, e.at);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      i_signal = '0;
      i_clear = '0;
      i_mode = '0;
      #2 rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         i_signal = 4'($urandom);
         i_clear = 4'($urandom);
         #1 check("rst_hold", 32'(obs), 0);
      end
      @(negedge clk);
      i_signal = 4'b0001;
      i_clear = '0;
      i_mode = 8'h00;
      rst = 1'b1;
      expect_at(5, "rel_pre", pack(1'b0, 4'b0000, 4'b0000, 4'b0000));
      expect_at(6, "rel_pulse", pack(1'b1, 4'b0001, 4'b0001, 4'b0001));
      expect_at(7, "rel_after", pack(1'b1, 4'b0001, 4'b0001, 4'b0000));
      drain();
      clear_all(4'b0001);

      c0 = cyc;
      i_signal = 4'b0011;
      for (int i = 1; i <= 10; i++) expect_at(i, "glitch", pack(1'b0, 4'b0000, 4'b0001, 4'b0000));
      go(c0 + 3);
      i_signal = 4'b0001;
      drain();
      i_signal = 4'b0011;
      expect_at(5, "stable_pre", pack(1'b0, 4'b0000, 4'b0001, 4'b0000));
      expect_at(6, "stable_pulse", pack(1'b1, 4'b0010, 4'b0011, 4'b0010));
      expect_at(7, "stable_once", pack(1'b1, 4'b0010, 4'b0011, 4'b0000));
      drain();
      i_signal = 4'b0000;
      i_clear = 4'hF;
      expect_at(1, "clr_fall", pack(1'b0, 4'b0000, 4'b0011, 4'b0000));
      expect_at(6, "fall_norise", pack(1'b0, 4'b0000, 4'b0000, 4'b0000));
      @(negedge clk);
      i_clear = 4'h0;
      drain();

      i_mode = {MODE_OFF, MODE_BOTH, MODE_FALL, MODE_RISE};
      base = pcnt;
      c0 = cyc;
      i_signal = 4'hF;
      expect_at(6, "mode_rise", pack(1'b1, 4'b0101, 4'b1111, 4'b0101));
      expect_at(7, "mode_rise_end", pack(1'b1, 4'b0101, 4'b1111, 4'b0000));
      expect_at(14, "mode_fall", pack(1'b1, 4'b0111, 4'b0000, 4'b0110));
      expect_at(15, "mode_fall_end", pack(1'b1, 4'b0111, 4'b0000, 4'b0000));
      go(c0 + 8);
      i_signal = 4'h0;
      drain();
      for (int k = 0; k < 4; k++) check($sformatf("mode_cnt%0d", k), pcnt[k] - base[k], want[k]);
      clear_all(4'b0000);

      c0 = cyc;
      i_signal = 4'b0100;
      expect_at(6, "prio_pulse", pack(1'b1, 4'b0100, 4'b0100, 4'b0100));
      expect_at(7, "prio_hold", pack(1'b1, 4'b0100, 4'b0100, 4'b0000));
      go(c0 + 5);
      i_clear = 4'b0100;
      @(negedge clk);
      i_clear = 4'b0000;
      go(c0 + 8);
      i_clear = 4'b0100;
      expect_at(1, "clr_later", pack(1'b0, 4'b0000, 4'b0100, 4'b0000));
      @(negedge clk);
      i_clear = 4'b0000;
      drain();
      i_signal = 4'b0000;
      expect_at(6, "both_fall", pack(1'b1, 4'b0100, 4'b0000, 4'b0100));
      drain();
      clear_all(4'b0000);

      i_mode = {MODE_OFF, MODE_BOTH, MODE_FALL, MODE_OFF};
      i_signal = 4'b0001;
      expect_at(6, "off_track", pack(1'b0, 4'b0000, 4'b0001, 4'b0000));
      drain();
      i_mode[1:0] = MODE_RISE;
      for (int i = 1; i <= 4; i++) expect_at(i, "mode_sw", pack(1'b0, 4'b0000, 4'b0001, 4'b0000));
      drain();
      i_signal = 4'b0000;
      expect_at(6, "sw_fall", pack(1'b0, 4'b0000, 4'b0000, 4'b0000));
      drain();
      i_signal = 4'b0001;
      expect_at(6, "sw_rise", pack(1'b1, 4'b0001, 4'b0001, 4'b0001));
      expect_at(7, "sw_rise_end", pack(1'b1, 4'b0001, 4'b0001, 4'b0000));
      drain();
      clear_all(4'b0001);

      i_mode = 8'h00;
      c0 = cyc;
      i_signal = 4'b0011;
      go(c0 + 4);
      rst = 1'b0;
      #1 check("rst_async", 32'(obs), 0);
      repeat (2) @(negedge clk);
      check("rst_low", 32'(obs), 0);
      rst = 1'b1;
      expect_at(5, "rerel_pre", pack(1'b0, 4'b0000, 4'b0000, 4'b0000));
      expect_at(6, "rerel_pulse", pack(1'b1, 4'b0011, 4'b0011, 4'b0011));
      expect_at(7, "rerel_after", pack(1'b1, 4'b0011, 4'b0011, 4'b0000));
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/edge_event_detector.md
# edge_event_detector

Multi-channel, parametrised edge detector for asynchronous control inputs (buttons, SPI/LCD status lines, external strobes). Each channel synchronises its input, debounces it with a programmable stability count, detects edges under a per-channel runtime mode, and reports a one-cycle pulse, the clean level, and a sticky event flag with software clear. It is the general-purpose input-conditioning front end feeding the SPI/LCD control FSMs.

## Interface
- `WIDTH`, 4: number of independent channels (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles required before the clean level updates. Values 0 and 1 behave identically: no filtering beyond one cycle.
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES+1)` (min 1): debounce counter width. Derived; not overridden.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `i_signal` in WIDTH: raw asynchronous inputs.
- `i_mode` in 2*WIDTH: channel n uses bits [2n+1:2n]. 00 = rising, 01 = falling, 10 = both, 11 = disabled.
- `i_clear` in WIDTH: per-channel synchronous clear of `o_event`.
- `o_pulse` out WIDTH: registered one-cycle edge pulse.
- `o_level` out WIDTH: registered debounced level.
- `o_event` out WIDTH: registered sticky edge flag.
- `o_any` out 1: OR of `o_event`. Combinational from registers.

## Operation
- **Reset:** All synchroniser flops, `o_level`, counters, `o_pulse` and `o_event` are 0. `o_any` is 0.
- **Synchroniser:** `i_signal[n]` feeds a `SYNC_STAGES`-deep shift chain. The last stage is `sync[n]`.
- **Debounce:**
  - When `sync[n] == o_level[n]`, the counter is set to 0.
  - When they differ and counter == max(D,1)−1, `o_level[n]` is set to `sync[n]` and the counter is set to 0.
  - Otherwise the counter increments.
  - Any single-cycle return to equality restarts the count.
- **Edge detection:** On the edge where `o_level[n]` toggles, `o_pulse[n]` is registered high for exactly one cycle if the transition matches the mode:
  - rising: 0→1
  - falling: 1→0
  - both: either
  - disabled: never
- At most one pulse can occur per toggle. Back-to-back toggles are impossible when D ≥ 2. With D ≤ 1, pulses on consecutive cycles are legal.
- **Sticky flag:**
  - `o_event[n]` is set on the same edge `o_pulse[n]` is set.
  - It is cleared at the edge where `i_clear[n]` = 1.
  - Simultaneous set and clear: set wins, so no event is lost.
- **Mode changes:** A mode change takes effect at the next edge. It never generates a pulse by itself. `o_level` keeps tracking in disabled mode.
- **Reset mid-operation:** All state returns to reset values immediately, and in-progress counts are discarded. An input held high across reset release produces a rising event after full latency. This is intended.

## Timing
- Input change first sampled at edge k → `o_level`/`o_pulse` change at edge k + SYNC_STAGES − 1 + max(DEBOUNCE_CYCLES,1). Defaults: 5 edges.
- `o_event` rises on the same edge as `o_pulse`. `o_any` follows in the same cycle.
- `i_clear` → `o_event` low at the next edge.
- Glitch shorter than max(D,1) cycles at `sync` → no level change, no pulse.
- Channels are fully independent; simultaneous events on all channels are each reported.

## Structure
- Package `edge_det_pkg`:
  - `MODE_RISE`/`MODE_FALL`/`MODE_BOTH`/`MODE_OFF` 2-bit constants.
  - Mode typedef.
- Sub-module `edge_det_channel`: holds synchroniser, counter, level, pulse and event for one channel, with scalar ports. The top instantiates it `WIDTH` times in a generate loop and reduces `o_event` to `o_any`.

## Test plan
- **Reset:** With `rst`=0 and inputs toggling, all outputs stay 0. Release with `i_signal`=4'b0001, mode rising → `o_pulse[0]` high for 1 cycle, 5 edges after release. `o_event[0]`=1 and `o_any`=1.
- **Glitch rejection:** With D=4, a 3-cycle high glitch on ch1 → no `o_level`/`o_pulse` change. A 4-cycle-stable high → `o_level[1]`=1 and a single pulse.
- **Modes:** Ch0–3 set to rise/fall/both/off, with the same 0→1→0 square wave on all. Expected pulses are 1/1/2/0. Ch3 `o_level` still toggles.
- **Clear priority:** Assert `i_clear[2]` on the exact edge a ch2 pulse is registered → `o_event[2]` stays 1. Clear again on a later cycle → 0. `o_any` drops when all are clear.
- **Mode change:** Switching ch0 from off to rising while `o_level[0]`=1 → no pulse. The next 0→1 produces a pulse.
- **Async reset mid-count:** Assert `rst` low at count 2 of 4 → counter and outputs 0 immediately. After release, the full 5-edge latency is restored.
